// File: rtl/ps2_key_tx.sv
// ps2_key_tx: device-side PS/2 keyboard transmitter.
// Takes one decimal digit, maps it to its Set-2 make code and sends a full
// keystroke (MAKE, F0, MAKE) as 11-bit odd-parity frames on ps2_clk_o/ps2_data_o.
//
// state  | meaning
// IDLE   | waiting for a handshake, lines high, key_ready high
// BIT_HI | first half of a bit slot: data presented, clock high
// BIT_LO | second half of a bit slot: clock low, host samples on the falling edge
// GAP    | idle spacing between bytes of one keystroke, both lines high
module ps2_key_tx #(
    parameter int HALF_CYC = 2500,
    parameter int GAP_CYC  = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic       key_ready,
    output logic       busy,
    output logic       err_invalid,
    output logic       ps2_clk_o,
    output logic       ps2_data_o
);

    localparam int PH_MAX = (HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC;
    localparam int PH_W   = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] HALF_LAST = PH_W'(HALF_CYC - 1);
    localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BIT_HI = 2'd1,
        BIT_LO = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t          state;
    logic [PH_W-1:0] phase;
    logic [3:0]      bit_idx;
    logic [1:0]      byte_idx;
    logic [7:0]      make_q;
    logic [10:0]     cur_frame;
    logic [3:0]      next_bit;

    function automatic logic [7:0] make_code(input logic [3:0] d);
        case (d)
            4'd0:    make_code = 8'h45;
            4'd1:    make_code = 8'h16;
            4'd2:    make_code = 8'h1E;
            4'd3:    make_code = 8'h26;
            4'd4:    make_code = 8'h25;
            4'd5:    make_code = 8'h2E;
            4'd6:    make_code = 8'h36;
            4'd7:    make_code = 8'h3D;
            4'd8:    make_code = 8'h3E;
            4'd9:    make_code = 8'h46;
            default: make_code = 8'h00;
        endcase
    endfunction

    // Frame slot order: start(0), data LSB first, odd parity, stop(1).
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        frame_of = {1'b1, ~^b, b, 1'b0};
    endfunction

    // Frame of the byte currently being sent; the middle byte is the break prefix.
    always_comb begin
        cur_frame = frame_of((byte_idx == 2'd1) ? 8'hF0 : make_q);
        next_bit  = bit_idx + 4'd1;
    end

    // Keystroke sequencer with registered PS/2 lines and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            make_q      <= '0;
            key_ready   <= 1'b1;
            busy        <= 1'b0;
            err_invalid <= 1'b0;
            ps2_clk_o   <= 1'b1;
            ps2_data_o  <= 1'b1;
        end else begin
            err_invalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        if (key_digit > 4'd9) begin
                            err_invalid <= 1'b1;
                        end else begin
                            make_q     <= make_code(key_digit);
                            state      <= BIT_HI;
                            phase      <= '0;
                            bit_idx    <= '0;
                            byte_idx   <= '0;
                            key_ready  <= 1'b0;
                            busy       <= 1'b1;
                            ps2_clk_o  <= 1'b1;
                            ps2_data_o <= 1'b0;
                        end
                    end
                end
                BIT_HI: begin
                    if (phase == HALF_LAST) begin
                        phase     <= '0;
                        state     <= BIT_LO;
                        ps2_clk_o <= 1'b0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                BIT_LO: begin
                    if (phase == HALF_LAST) begin
                        phase     <= '0;
                        ps2_clk_o <= 1'b1;
                        if (bit_idx == 4'd10) begin
                            bit_idx    <= '0;
                            ps2_data_o <= 1'b1;
                            if (byte_idx == 2'd2) begin
                                byte_idx  <= '0;
                                state     <= IDLE;
                                busy      <= 1'b0;
                                key_ready <= 1'b1;
                            end else begin
                                byte_idx <= byte_idx + 2'd1;
                                state    <= GAP;
                            end
                        end else begin
                            bit_idx    <= next_bit;
                            ps2_data_o <= cur_frame[next_bit];
                            state      <= BIT_HI;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                GAP: begin
                    if (phase == GAP_LAST) begin
                        phase      <= '0;
                        state      <= BIT_HI;
                        ps2_data_o <= 1'b0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
